// File: rtl/transceiver_link_ctrl_pkg.sv
// Shared types and constants for the transceiver link bring-up controller.
// Contents: FSM state encoding, default K-characters, PHY transmit symbol
// payload type and a small sizing helper.
package transceiver_link_ctrl_pkg;

    // Link bring-up states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAL_WAIT = 3'd1,
        ST_BACKOFF  = 3'd2,
        ST_UP       = 3'd3,
        ST_FAIL     = 3'd4
    } link_state_e;

    // K28.5: sent while calibrating or backing off.
    localparam logic [7:0] K28_5_TRAIN = 8'hBC;
    // K28.1: sent when idle, disabled, failed, or no upper-layer data.
    localparam logic [7:0] K28_1_IDLE  = 8'h3C;

    // One transmit symbol towards the PHY.
    typedef struct packed {
        logic       k_en;
        logic [7:0] data;
    } tx_sym_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/transceiver_link_ctrl_timer.sv
// Loadable up-counter with terminal-count flag, shared by the calibration
// timeout and back-off phases.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   clr_i     reload the count to 0 (wins over en_i)
//   en_i      advance the count by one
//   tc_val_i  terminal count value
//   tc_o      count equals tc_val_i (decoded from the count register)
module transceiver_link_ctrl_timer #(
    parameter int unsigned W = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/transceiver_link_ctrl.sv
// Link bring-up controller above the transceiver PHY: sequences receiver
// calibration with timeout and bounded retries with back-off, and drives the
// PHY transmit stream (K-characters while down, upper-layer data while up).
// Ports:
//   i_clk_120, i_clk_120_rst     clock, synchronous active-high reset
//   i_link_en                    1 = bring up / hold link, 0 = drop it
//   o_cal_start                  one-cycle calibration start pulse
//   i_cal_done, i_cal_fail       PHY calibration result
//   i_tx_valid/k_en/byte         upper-layer transmit byte
//   o_tx_ready                   upper layer may transfer (state decode)
//   o_packet_k_en/byte           registered symbol to PHY transmitter
//   o_link_up, o_link_fail       link status
//   o_retry_cnt                  calibration retries used
module transceiver_link_ctrl
    import transceiver_link_ctrl_pkg::*;
#(
    parameter int unsigned CAL_TIMEOUT    = 4096,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned BACKOFF_CYCLES = 256,
    parameter logic [7:0]  TRAIN_K        = K28_5_TRAIN,
    parameter logic [7:0]  IDLE_K         = K28_1_IDLE,
    localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          i_clk_120,
    input  logic          i_clk_120_rst,
    input  logic          i_link_en,
    output logic          o_cal_start,
    input  logic          i_cal_done,
    input  logic          i_cal_fail,
    input  logic          i_tx_valid,
    input  logic          i_tx_k_en,
    input  logic [7:0]    i_tx_byte,
    output logic          o_tx_ready,
    output logic          o_packet_k_en,
    output logic [7:0]    o_packet_byte,
    output logic          o_link_up,
    output logic          o_link_fail,
    output logic [RW-1:0] o_retry_cnt
);

    localparam int unsigned TMAX = max_u(CAL_TIMEOUT, BACKOFF_CYCLES);
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    link_state_e   state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          cal_start_q, cal_start_d;
    logic          link_up_q, link_up_d;
    logic          link_fail_q, link_fail_d;
    tx_sym_t       pkt_q, pkt_d;

    logic          tmr_clr_c;
    logic          tmr_en_c;
    logic          tmr_tc;
    logic [TW-1:0] tmr_tc_val;

    // Terminal count follows the phase currently being timed.
    assign tmr_tc_val = (state_q == ST_BACKOFF) ? TW'(BACKOFF_CYCLES - 1)
                                                : TW'(CAL_TIMEOUT - 1);

    transceiver_link_ctrl_timer #(
        .W (TW)
    ) u_timer (
        .clk_i    (i_clk_120),
        .rst_i    (i_clk_120_rst),
        .clr_i    (tmr_clr_c),
        .en_i     (tmr_en_c),
        .tc_val_i (tmr_tc_val),
        .tc_o     (tmr_tc)
    );

    // Next-state, counter control and registered-output next values.
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        tmr_clr_c = 1'b0;
        tmr_en_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_link_en) begin
                    state_d   = ST_CAL_WAIT;
                    retry_d   = '0;
                    tmr_clr_c = 1'b1;
                end
            end
            ST_CAL_WAIT: begin
                tmr_en_c = 1'b1;
                // Fail beats done; done beats a same-cycle timeout.
                if (i_cal_fail || (!i_cal_done && tmr_tc)) begin
                    tmr_clr_c = 1'b1;
                    if (retry_q == RW'(MAX_RETRIES)) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        state_d = ST_BACKOFF;
                    end
                end else if (i_cal_done) begin
                    state_d = ST_UP;
                end
            end
            ST_BACKOFF: begin
                tmr_en_c = 1'b1;
                if (tmr_tc) begin
                    state_d   = ST_CAL_WAIT;
                    tmr_clr_c = 1'b1;
                end
            end
            ST_UP:   state_d = ST_UP;
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase

        // Dropping the enable overrides every other transition.
        if (!i_link_en) begin
            state_d   = ST_IDLE;
            retry_d   = '0;
            tmr_clr_c = 1'b1;
        end

        cal_start_d = (state_d == ST_CAL_WAIT) && (state_q != ST_CAL_WAIT);
        link_up_d   = (state_d == ST_UP);
        link_fail_d = (state_d == ST_FAIL);

        // A byte accepted in UP is emitted even if the link drops that cycle.
        if ((state_q == ST_UP) && i_tx_valid) begin
            pkt_d = '{k_en: i_tx_k_en, data: i_tx_byte};
        end else if ((state_d == ST_CAL_WAIT) || (state_d == ST_BACKOFF)) begin
            pkt_d = '{k_en: 1'b1, data: TRAIN_K};
        end else begin
            pkt_d = '{k_en: 1'b1, data: IDLE_K};
        end
    end

    always_ff @(posedge i_clk_120) begin
        if (i_clk_120_rst) begin
            state_q     <= ST_IDLE;
            retry_q     <= '0;
            cal_start_q <= 1'b0;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
            pkt_q       <= '{k_en: 1'b1, data: IDLE_K};
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            cal_start_q <= cal_start_d;
            link_up_q   <= link_up_d;
            link_fail_q <= link_fail_d;
            pkt_q       <= pkt_d;
        end
    end

    assign o_tx_ready    = (state_q == ST_UP);
    assign o_cal_start   = cal_start_q;
    assign o_link_up     = link_up_q;
    assign o_link_fail   = link_fail_q;
    assign o_retry_cnt   = retry_q;
    assign o_packet_k_en = pkt_q.k_en;
    assign o_packet_byte = pkt_q.data;

endmodule

// File: tb/tb_transceiver_link_ctrl.sv
// Self-checking bench for transceiver_link_ctrl (CAL_TIMEOUT=16,
// MAX_RETRIES=3, BACKOFF_CYCLES=256).
module tb_transceiver_link_ctrl;

    localparam logic [7:0] IK = 8'h3C;
    localparam logic [7:0] TK = 8'hBC;

    typedef struct packed {
        logic       cal_start;
        logic       tx_ready;
        logic       link_up;
        logic       link_fail;
        logic [1:0] retry;
        logic       k_en;
        logic [7:0] pb;
    } exp_t;

    typedef struct {
        logic       valid;
        logic       k;
        logic [7:0] b;
        logic       done;
        logic       fail;
        exp_t       exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       link_en;
    logic       cal_start;
    logic       cal_done;
    logic       cal_fail;
    logic       tx_valid;
    logic       tx_k_en;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       pkt_k_en;
    logic [7:0] pkt_byte;
    logic       link_up;
    logic       link_fail;
    logic [1:0] retry_cnt;

    int n_vec = 0;
    int n_bad = 0;

    exp_t  exp_q[$];
    string nm_q[$];
    vec_t  tbl[13];

    transceiver_link_ctrl #(
        .CAL_TIMEOUT    (16),
        .MAX_RETRIES    (3),
        .BACKOFF_CYCLES (256)
    ) dut (
        .i_clk_120     (clk),
        .i_clk_120_rst (rst),
        .i_link_en     (link_en),
        .o_cal_start   (cal_start),
        .i_cal_done    (cal_done),
        .i_cal_fail    (cal_fail),
        .i_tx_valid    (tx_valid),
        .i_tx_k_en     (tx_k_en),
        .i_tx_byte     (tx_byte),
        .o_tx_ready    (tx_ready),
        .o_packet_k_en (pkt_k_en),
        .o_packet_byte (pkt_byte),
        .o_link_up     (link_up),
        .o_link_fail   (link_fail),
        .o_retry_cnt   (retry_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t ex(input logic cs, input logic rdy, input logic up,
                                input logic fl, input logic [1:0] rc,
                                input logic k, input logic [7:0] b);
        exp_t e;
        e.cal_start = cs;
        e.tx_ready  = rdy;
        e.link_up   = up;
        e.link_fail = fl;
        e.retry     = rc;
        e.k_en      = k;
        e.pb        = b;
        return e;
    endfunction

    function automatic exp_t ex_idle();
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, IK);
    endfunction

    function automatic exp_t ex_train(input logic cs, input logic [1:0] rc);
        return ex(cs, 1'b0, 1'b0, 1'b0, rc, 1'b1, TK);
    endfunction

    function automatic exp_t ex_up(input logic k, input logic [7:0] b);
        return ex(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, k, b);
    endfunction

    function automatic exp_t ex_fail();
        return ex(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, IK);
    endfunction

    function automatic vec_t mkv(input logic v, input logic k, input logic [7:0] b,
                                 input logic d, input logic f, input exp_t e);
        vec_t r;
        r.valid = v;
        r.k     = k;
        r.b     = b;
        r.done  = d;
        r.fail  = f;
        r.exp   = e;
        return r;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input string nm, input logic r, input logic en,
                        input logic dn, input logic fl, input logic vl,
                        input logic k, input logic [7:0] b, input exp_t e);
        exp_t  want;
        exp_t  act;
        string n;
        rst      = r;
        link_en  = en;
        cal_done = dn;
        cal_fail = fl;
        tx_valid = vl;
        tx_k_en  = k;
        tx_byte  = b;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        want          = exp_q.pop_front();
        n             = nm_q.pop_front();
        act.cal_start = cal_start;
        act.tx_ready  = tx_ready;
        act.link_up   = link_up;
        act.link_fail = link_fail;
        act.retry     = retry_cnt;
        act.k_en      = pkt_k_en;
        act.pb        = pkt_byte;
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got cs=%b rdy=%b up=%b fl=%b rc=%0d k=%b b=%h, want cs=%b rdy=%b up=%b fl=%b rc=%0d k=%b b=%h",
                     n, $time, act.cal_start, act.tx_ready, act.link_up, act.link_fail,
                     act.retry, act.k_en, act.pb, want.cal_start, want.tx_ready,
                     want.link_up, want.link_fail, want.retry, want.k_en, want.pb);
        end
    endtask

    initial begin
        // UP-state stream: valid, k, byte, cal_done, cal_fail, expected symbol.
        tbl[0]  = mkv(1'b1, 1'b0, 8'h01, 1'b0, 1'b0, ex_up(1'b0, 8'h01));
        tbl[1]  = mkv(1'b0, 1'b0, 8'hEE, 1'b0, 1'b1, ex_up(1'b1, IK));
        tbl[2]  = mkv(1'b1, 1'b0, 8'h02, 1'b0, 1'b0, ex_up(1'b0, 8'h02));
        tbl[3]  = mkv(1'b1, 1'b0, 8'h03, 1'b0, 1'b0, ex_up(1'b0, 8'h03));
        tbl[4]  = mkv(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, ex_up(1'b1, IK));
        tbl[5]  = mkv(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, ex_up(1'b1, 8'h04));
        tbl[6]  = mkv(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, ex_up(1'b1, IK));
        tbl[7]  = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ex_up(1'b1, IK));
        tbl[8]  = mkv(1'b1, 1'b0, 8'h05, 1'b0, 1'b0, ex_up(1'b0, 8'h05));
        tbl[9]  = mkv(1'b1, 1'b0, 8'h06, 1'b0, 1'b1, ex_up(1'b0, 8'h06));
        tbl[10] = mkv(1'b1, 1'b0, 8'h07, 1'b0, 1'b0, ex_up(1'b0, 8'h07));
        tbl[11] = mkv(1'b1, 1'b0, 8'h08, 1'b0, 1'b0, ex_up(1'b0, 8'h08));
        tbl[12] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ex_up(1'b1, IK));

        rst = 1'b1; link_en = 1'b0; cal_done = 1'b0; cal_fail = 1'b0;
        tx_valid = 1'b0; tx_k_en = 1'b0; tx_byte = 8'h00;

        // Reset values.
        step("reset0", 1, 0, 0, 0, 0, 0, 8'h00, ex_idle());
        step("reset1", 1, 0, 0, 0, 0, 0, 8'h00, ex_idle());
        step("idle_hold", 0, 0, 0, 0, 0, 0, 8'h00, ex_idle());

        // Bring-up: done 10 cycles after the single start pulse.
        step("bringup_start", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b1, 2'd0));
        for (int i = 0; i < 10; i++)
            step("bringup_wait", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b0, 2'd0));
        step("bringup_done", 0, 1, 1, 0, 0, 0, 8'h00, ex_up(1'b1, IK));

        // Data streaming, calibration inputs ignored while UP.
        for (int i = 0; i < 13; i++)
            step("up_stream", 0, 1, tbl[i].done, tbl[i].fail, tbl[i].valid,
                 tbl[i].k, tbl[i].b, tbl[i].exp);

        // Drop mid-UP with a byte in flight.
        step("drop_up_inflight", 0, 0, 0, 0, 1, 0, 8'h55,
             ex(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h55));
        for (int i = 0; i < 5; i++)
            step("drop_up_idle", 0, 0, 0, 0, 1, 1, 8'hAA, ex_idle());

        // Repeated timeouts: retries 1,2,3 then FAIL.
        step("to_start", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b1, 2'd0));
        for (int a = 0; a < 4; a++) begin
            for (int t = 0; t < 15; t++)
                step("to_wait", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b0, 2'(a)));
            if (a < 3) begin
                step("to_backoff", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b0, 2'(a + 1)));
                for (int t = 0; t < 255; t++)
                    step("bo_wait", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b0, 2'(a + 1)));
                step("bo_restart", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b1, 2'(a + 1)));
            end else begin
                step("to_fail", 0, 1, 0, 0, 0, 0, 8'h00, ex_fail());
            end
        end
        for (int i = 0; i < 5; i++)
            step("fail_hold", 0, 1, 1, 0, 0, 0, 8'h00, ex_fail());
        step("fail_drop", 0, 0, 0, 0, 0, 0, 8'h00, ex_idle());

        // Done and fail together: fail wins, then drop mid-BACKOFF.
        step("sim_start", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b1, 2'd0));
        for (int i = 0; i < 2; i++)
            step("sim_wait", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b0, 2'd0));
        step("sim_done_fail", 0, 1, 1, 1, 0, 0, 8'h00, ex_train(1'b0, 2'd1));
        for (int i = 0; i < 20; i++)
            step("sim_backoff", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b0, 2'd1));
        step("drop_backoff", 0, 0, 0, 0, 0, 0, 8'h00, ex_idle());
        for (int i = 0; i < 300; i++)
            step("dropped_no_start", 0, 0, 0, 0, 0, 0, 8'h00, ex_idle());

        // Done on the timeout cycle: done wins.
        step("dto_start", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b1, 2'd0));
        for (int i = 0; i < 15; i++)
            step("dto_wait", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b0, 2'd0));
        step("done_at_timeout", 0, 1, 1, 0, 0, 0, 8'h00, ex_up(1'b1, IK));
        step("dto_up_hold", 0, 1, 0, 0, 0, 0, 8'h00, ex_up(1'b1, IK));
        step("dto_drop", 0, 0, 0, 0, 0, 0, 8'h00, ex_idle());

        // Reset during CAL_WAIT: pending done is ignored.
        step("rst_cal_start", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b1, 2'd0));
        for (int i = 0; i < 3; i++)
            step("rst_cal_wait", 0, 1, 0, 0, 0, 0, 8'h00, ex_train(1'b0, 2'd0));
        step("rst_in_cal", 1, 1, 1, 0, 0, 0, 8'h00, ex_idle());
        step("post_rst_restart", 0, 1, 1, 0, 0, 0, 8'h00, ex_train(1'b1, 2'd0));
        step("post_rst_done", 0, 1, 1, 0, 0, 0, 8'h00, ex_up(1'b1, IK));
        step("final_drop", 0, 0, 0, 0, 0, 0, 8'h00, ex_idle());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
